// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
//   scan_state_t : scanner FSM states
//   kbits_f      : width of a key code for a given key count
//   key_code_f   : packs (column, row) into a linear key code
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESS    = 2'd2,
    RELEASE  = 2'd3
  } scan_state_t;

  // Minimum of one bit so a single-entry index still has a legal width.
  function automatic int unsigned kbits_f(input int unsigned nkeys);
    return (nkeys > 1) ? $clog2(nkeys) : 1;
  endfunction

  localparam int unsigned DEF_NCOLS = 4;
  localparam int unsigned DEF_NROWS = 4;
  localparam int unsigned DEF_KBITS = kbits_f(DEF_NCOLS * DEF_NROWS);

  function automatic int unsigned key_code_f(input int unsigned col,
                                             input int unsigned row,
                                             input int unsigned nrows = DEF_NROWS);
    return col * nrows + row;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous active-low row lines.
//   clk, reset_n : clock and synchronous active-low reset
//   row_n        : raw row sense, active low
//   rows         : synchronized row sense, active high
module keypad_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] row_n,
  output logic [WIDTH-1:0] rows
);

  logic [WIDTH-1:0] meta_n;

  // Inversion folded into the second stage so the output is a plain flop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_n <= '1;
      rows   <= '0;
    end else begin
      meta_n <= row_n;
      rows   <= ~meta_n;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: walks the columns, debounces the first active key
// with one shared counter and emits one event per press on valid/ready.
//   clk, reset_n : clock and synchronous active-low reset
//   col_n        : column drive, active low, at most one bit low
//   row_n        : raw row sense, active low, asynchronous
//   key_valid    : press event available
//   key_code     : col*NROWS + row of the event
//   key_ready    : consumer accepts the event
//   key_held     : confirmed key currently down
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned NCOLS  = 4,
  parameter int unsigned NROWS  = 4,
  parameter int unsigned SETTLE = 16,
  parameter int unsigned NDELAY = 65000,
  parameter int unsigned NBITS  = 20,
  parameter int unsigned KBITS  = kbits_f(NROWS * NCOLS)
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [NCOLS-1:0] col_n,
  input  logic [NROWS-1:0] row_n,
  output logic             key_valid,
  output logic [KBITS-1:0] key_code,
  input  logic             key_ready,
  output logic             key_held
);

  localparam int unsigned CBITS = kbits_f(NCOLS);
  localparam int unsigned RBITS = kbits_f(NROWS);

  scan_state_t      state, state_nx;
  logic [CBITS-1:0] c, c_nx, c_inc;
  logic [RBITS-1:0] r, r_nx, low_idx;
  logic [NBITS-1:0] cnt, cnt_nx;
  logic [NCOLS-1:0] col_nx;
  logic             valid_nx, held_nx;
  logic [KBITS-1:0] code_nx;
  logic [NROWS-1:0] rows;

  keypad_sync #(.WIDTH(NROWS)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .row_n   (row_n),
    .rows    (rows)
  );

  // Lowest active row wins when several rows are down together.
  always_comb begin
    low_idx = '0;
    for (int i = NROWS - 1; i >= 0; i--) begin
      if (rows[i]) low_idx = RBITS'(i);
    end
  end

  assign c_inc = (c == CBITS'(NCOLS - 1)) ? '0 : c + CBITS'(1);

  // Next-state and output decode.
  always_comb begin
    state_nx = state;
    c_nx     = c;
    r_nx     = r;
    cnt_nx   = cnt;
    valid_nx = key_valid;
    held_nx  = key_held;
    code_nx  = key_code;
    unique case (state)
      SCAN: begin
        if (&col_n) begin
          // First cycle out of reset: no column driven yet, hold the count.
          cnt_nx = '0;
        end else if (cnt == NBITS'(SETTLE)) begin
          cnt_nx = '0;
          if (|rows) begin
            r_nx     = low_idx;
            state_nx = DEBOUNCE;
          end else begin
            c_nx = c_inc;
          end
        end else begin
          cnt_nx = cnt + NBITS'(1);
        end
      end
      DEBOUNCE: begin
        if (!rows[r]) begin
          c_nx     = c_inc;
          cnt_nx   = '0;
          state_nx = SCAN;
        end else if (cnt == NBITS'(NDELAY - 1)) begin
          // The sample cycle already saw the key, so it is the first stable cycle.
          code_nx  = KBITS'(key_code_f(32'(c), 32'(r), NROWS));
          valid_nx = 1'b1;
          held_nx  = 1'b1;
          cnt_nx   = '0;
          state_nx = PRESS;
        end else begin
          cnt_nx = cnt + NBITS'(1);
        end
      end
      PRESS: begin
        if (key_ready) begin
          valid_nx = 1'b0;
          cnt_nx   = '0;
          state_nx = RELEASE;
        end
      end
      RELEASE: begin
        if (rows[r]) begin
          cnt_nx = '0;
        end else if (cnt == NBITS'(NDELAY)) begin
          held_nx  = 1'b0;
          c_nx     = c_inc;
          cnt_nx   = '0;
          state_nx = SCAN;
        end else begin
          cnt_nx = cnt + NBITS'(1);
        end
      end
      default: state_nx = SCAN;
    endcase
    col_nx = ~(NCOLS'(1) << c_nx);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= SCAN;
      c         <= '0;
      r         <= '0;
      cnt       <= '0;
      col_n     <= '1;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      key_code  <= '0;
    end else begin
      state     <= state_nx;
      c         <= c_nx;
      r         <= r_nx;
      cnt       <= cnt_nx;
      col_n     <= col_nx;
      key_valid <= valid_nx;
      key_held  <= held_nx;
      key_code  <= code_nx;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a physical keypad model feeds the
// DUT, a behavioural reference is compared every cycle, and directed scenarios
// pin absolute latencies with hand-computed values.
module tb_keypad_scanner;

  localparam int unsigned NCOLS  = 4;
  localparam int unsigned NROWS  = 4;
  localparam int unsigned SETTLE = 4;
  localparam int unsigned NDELAY = 8;
  localparam int unsigned NBITS  = 20;
  localparam int unsigned KBITS  = 4;
  localparam int unsigned NKEYS  = NCOLS * NROWS;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [NCOLS-1:0] col_n;
  logic [NROWS-1:0] row_n;
  logic             key_valid;
  logic [KBITS-1:0] key_code;
  logic             key_ready = 1'b0;
  logic             key_held;
  logic [NKEYS-1:0] press_map = '0;

  int checks = 0;
  int errors = 0;
  int acc_dut = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .NCOLS(NCOLS), .NROWS(NROWS), .SETTLE(SETTLE), .NDELAY(NDELAY), .NBITS(NBITS)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .col_n     (col_n),
    .row_n     (row_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .key_held  (key_held)
  );

  // A pressed key shorts its column line to its row line.
  always_comb begin
    row_n = '1;
    for (int cc = 0; cc < NCOLS; cc++)
      for (int rr = 0; rr < NROWS; rr++)
        if (col_n[cc] === 1'b0 && press_map[cc*NROWS+rr]) row_n[rr] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural reference ----------------
  localparam int M_SCAN = 0, M_CONFIRM = 1, M_WAIT = 2, M_RELEASE = 3;
  int               m_mode, m_col, m_row, m_dwell, m_seen, m_code, m_events = 0;
  bit               m_drive, m_valid, m_held;
  logic [NROWS-1:0] m_s1, m_s2;

  function automatic int lowest(input logic [NROWS-1:0] v);
    int idx = 0;
    for (int i = NROWS - 1; i >= 0; i--) if (v[i]) idx = i;
    return idx;
  endfunction

  task automatic model_step();
    logic [NROWS-1:0] rows;
    if (!reset_n) begin
      m_mode = M_SCAN; m_col = 0; m_row = 0; m_dwell = 0; m_seen = 0;
      m_code = 0; m_drive = 0; m_valid = 0; m_held = 0;
      m_s1 = '1; m_s2 = '1;
      return;
    end
    // Rows seen by the scanner are the raw rows two cycles ago, inverted.
    rows = ~m_s2;
    m_s2 = m_s1;
    m_s1 = row_n;
    case (m_mode)
      M_SCAN: begin
        if (!m_drive) m_drive = 1;
        else if (m_dwell < int'(SETTLE)) m_dwell++;
        else if (rows == '0) begin m_col = (m_col + 1) % NCOLS; m_dwell = 0; end
        else begin m_row = lowest(rows); m_seen = 1; m_mode = M_CONFIRM; end
      end
      M_CONFIRM: begin
        if (!rows[m_row]) begin m_col = (m_col + 1) % NCOLS; m_dwell = 0; m_mode = M_SCAN; end
        else begin
          m_seen++;
          if (m_seen == NDELAY + 1) begin
            m_code = m_col * NROWS + m_row; m_valid = 1; m_held = 1; m_mode = M_WAIT;
          end
        end
      end
      M_WAIT: begin
        if (key_ready) begin m_valid = 0; m_seen = 0; m_events++; m_mode = M_RELEASE; end
      end
      default: begin
        if (rows[m_row]) m_seen = 0;
        else begin
          m_seen++;
          if (m_seen == NDELAY + 1) begin
            m_held = 0; m_col = (m_col + 1) % NCOLS; m_dwell = 0; m_mode = M_SCAN;
          end
        end
      end
    endcase
  endtask

  // Compare current outputs against the reference, then advance it.
  always @(negedge clk) begin
    logic [NCOLS-1:0] exp_col;
    if (cmp_on) begin
      exp_col = m_drive ? ~(NCOLS'(1) << m_col) : '1;
      chk("model_col_n", 32'(col_n), 32'(exp_col));
      chk("model_key_valid", 32'(key_valid), 32'(m_valid));
      chk("model_key_code", 32'(key_code), 32'(m_code));
      chk("model_key_held", 32'(key_held), 32'(m_held));
    end
    if (reset_n && key_valid && key_ready) acc_dut++;
    model_step();
  end

  // ---------------- directed helpers ----------------
  // which: 0 col_n, 1 key_valid, 2 key_held. n = negedges waited.
  task automatic wait_for(input string name, input int which, input logic [31:0] want,
                          input int limit, output int n);
    logic [31:0] cur;
    n = 0;
    checks++;
    forever begin
      cur = (which == 0) ? 32'(col_n) : (which == 1) ? 32'(key_valid) : 32'(key_held);
      if (cur === want) break;
      if (n >= limit) begin
        errors++;
        $display("FAIL %s timeout: got %0h expected %0h after %0d cycles", name, cur, want, n);
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic cyc_drive();
    @(posedge clk);
    #1;
  endtask

  logic [NCOLS-1:0] scan_seq [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

  initial begin
    int n, acc0, stable;
    logic [NCOLS-1:0] prev;

    // Reset values.
    key_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 cmp_on = 1'b1;
    @(negedge clk);
    chk("reset_col_n", 32'(col_n), 32'hF);
    chk("reset_valid", 32'(key_valid), 32'h0);
    chk("reset_code", 32'(key_code), 32'h0);
    chk("reset_held", 32'(key_held), 32'h0);

    // Idle scan order and dwell.
    acc0 = acc_dut;
    cyc_drive(); reset_n = 1'b1;
    @(negedge clk); chk("first_cycle_col_n", 32'(col_n), 32'hF);
    @(negedge clk); chk("first_drive_col_n", 32'(col_n), 32'(scan_seq[0]));
    prev = col_n;
    for (int i = 1; i < 5; i++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (col_n === prev && n < 20);
      chk("scan_dwell", 32'(n), 32'(SETTLE + 1));
      chk("scan_order", 32'(col_n), 32'(scan_seq[i]));
      prev = col_n;
    end
    chk("idle_no_event", 32'(acc_dut - acc0), 32'h0);

    // Single press of key 6 with ready high.
    acc0 = acc_dut;
    cyc_drive(); press_map[6] = 1'b1;
    @(negedge clk);
    wait_for("press_col1", 0, 32'hD, 40, n);
    wait_for("press_valid", 1, 32'h1, 40, n);
    chk("press_latency", 32'(n), 32'd13);
    chk("press_code", 32'(key_code), 32'd6);
    @(negedge clk); chk("valid_falls", 32'(key_valid), 32'h0);
    cyc_drive(); press_map[6] = 1'b0;
    @(negedge clk);
    wait_for("release_held", 2, 32'h0, 40, n);
    chk("release_latency", 32'(n), 32'd11);
    chk("resume_col2", 32'(col_n), 32'hB);
    chk("press_one_event", 32'(acc_dut - acc0), 32'h1);

    // One-cycle bounce at debounce count 5.
    acc0 = acc_dut;
    wait_for("bounce_col0", 0, 32'hE, 40, n);
    cyc_drive(); press_map[6] = 1'b1;
    @(negedge clk);
    wait_for("bounce_col1", 0, 32'hD, 40, n);
    repeat (8) cyc_drive();
    press_map[6] = 1'b0;
    cyc_drive(); press_map[6] = 1'b1;
    cyc_drive(); press_map[6] = 1'b0;
    @(negedge clk);
    @(negedge clk); chk("bounce_next_col", 32'(col_n), 32'hB);
    repeat (40) @(negedge clk);
    chk("bounce_no_event", 32'(acc_dut - acc0), 32'h0);

    // Consumer stalls for 20 cycles.
    acc0 = acc_dut;
    key_ready = 1'b0;
    cyc_drive(); press_map[6] = 1'b1;
    @(negedge clk);
    wait_for("stall_valid", 1, 32'h1, 100, n);
    stable = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (key_valid === 1'b1 && key_code === 4'd6) stable++;
    end
    chk("stall_stable", 32'(stable), 32'd20);
    cyc_drive(); key_ready = 1'b1;
    @(negedge clk);
    cyc_drive(); press_map[6] = 1'b0;
    @(negedge clk);
    wait_for("stall_held", 2, 32'h0, 40, n);
    chk("stall_one_event", 32'(acc_dut - acc0), 32'h1);

    // Two rows in column 0; bounce on row 0 during release.
    acc0 = acc_dut;
    cyc_drive(); press_map[0] = 1'b1; press_map[3] = 1'b1;
    @(negedge clk);
    wait_for("multi_valid", 1, 32'h1, 100, n);
    chk("multi_code", 32'(key_code), 32'h0);
    cyc_drive(); press_map = '0;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc_drive();
      if (k == 5) press_map[0] = 1'b1;
      if (k == 6) press_map[0] = 1'b0;
      if (key_held === 1'b0) begin n = k; break; end
    end
    chk("release_bounce_latency", 32'(n), 32'd17);
    repeat (60) @(negedge clk);
    chk("multi_one_event", 32'(acc_dut - acc0), 32'h1);

    // Reset during DEBOUNCE.
    wait_for("rst_deb_col0", 0, 32'hE, 40, n);
    cyc_drive(); press_map[6] = 1'b1;
    @(negedge clk);
    wait_for("rst_deb_col1", 0, 32'hD, 40, n);
    repeat (7) cyc_drive();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_deb_col_n", 32'(col_n), 32'hF);
    chk("rst_deb_valid", 32'(key_valid), 32'h0);
    chk("rst_deb_held", 32'(key_held), 32'h0);
    press_map = '0;
    cyc_drive(); reset_n = 1'b1;
    @(negedge clk); chk("rst_deb_idle", 32'(col_n), 32'hF);
    @(negedge clk); chk("rst_deb_restart", 32'(col_n), 32'hE);

    // Reset during PRESS discards the pending event.
    key_ready = 1'b0;
    cyc_drive(); press_map[6] = 1'b1;
    @(negedge clk);
    wait_for("rst_prs_valid", 1, 32'h1, 100, n);
    cyc_drive(); reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_prs_col_n", 32'(col_n), 32'hF);
    chk("rst_prs_valid", 32'(key_valid), 32'h0);
    chk("rst_prs_held", 32'(key_held), 32'h0);
    press_map = '0;
    key_ready = 1'b1;
    cyc_drive(); reset_n = 1'b1;
    @(negedge clk); chk("rst_prs_idle", 32'(col_n), 32'hF);
    @(negedge clk); chk("rst_prs_restart", 32'(col_n), 32'hE);

    // Randomized presses, bounces, stalls and resets against the reference.
    for (int it = 0; it < 40; it++) begin
      int hold, idle;
      press_map = NKEYS'(1) << $urandom_range(0, NKEYS - 1);
      if ($urandom_range(0, 3) == 0) press_map |= NKEYS'(1) << $urandom_range(0, NKEYS - 1);
      hold = $urandom_range(5, 120);
      for (int k = 0; k < hold; k++) begin
        cyc_drive();
        key_ready = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 15) == 0) press_map ^= NKEYS'(1) << $urandom_range(0, NKEYS - 1);
      end
      press_map = '0;
      idle = $urandom_range(10, 60);
      for (int k = 0; k < idle; k++) begin
        cyc_drive();
        key_ready = ($urandom_range(0, 2) != 0);
      end
      if ($urandom_range(0, 9) == 0) begin
        reset_n = 1'b0;
        cyc_drive();
        reset_n = 1'b1;
      end
    end
    key_ready = 1'b1;
    press_map = '0;
    repeat (100) @(negedge clk);
    chk("event_total", 32'(acc_dut), 32'(m_events));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
